// File: rtl/muldiv_pkg.sv
// Shared op/state encodings and width check for the multiply/divide unit.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  function automatic bit width_ok(input int w);
    return (w >= 4) && ((w % 2) == 0);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step on a {hi,lo} accumulator.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               i_div,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_opnd,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_rem_sh;
  logic [WIDTH:0] w_diff;

  always_comb begin
    w_sum    = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opnd} : {(WIDTH+1){1'b0}});
    // Partial remainder shifted left with the next dividend bit; needs one extra bit.
    w_rem_sh = i_acc[2*WIDTH-1:WIDTH-1];
    w_diff   = w_rem_sh - {1'b0, i_opnd};
    if (i_div) begin
      if (w_diff[WIDTH]) o_acc = {w_rem_sh[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
      else               o_acc = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
    end else begin
      o_acc = {w_sum, i_acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO; WIDTH+2 cycle latency, busy stalls the pipe.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier (multiply latency 2, divide unchanged).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("muldiv_unit: WIDTH must be >= 4 and even");
  end

  state_e               r_state;
  state_e               w_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_opnd;
  logic                 r_div, r_neg, r_rneg, r_dz;
  logic [WIDTH-1:0]     r_hi, r_lo;
  logic                 r_done;

  logic                 w_signed, w_is_div, w_sa, w_sb, w_dz, w_skip_calc, w_launch, w_last;
  logic [WIDTH-1:0]     w_mag_a, w_mag_b;
  logic [2*WIDTH-1:0]   w_acc_init, w_step, w_prod;
  logic [WIDTH-1:0]     w_quo, w_rem, w_res_hi, w_res_lo;

  always_comb begin
    w_signed = 1'b0;
    w_is_div = 1'b0;
    case (op)
      OP_MULT:  w_signed = 1'b1;
      OP_MULTU: w_signed = 1'b0;
      OP_DIV:   begin w_signed = 1'b1; w_is_div = 1'b1; end
      OP_DIVU:  w_is_div = 1'b1;
      default:  w_signed = 1'b0;
    endcase
  end

  // Negating the most negative value wraps to itself, which is its correct unsigned magnitude.
  assign w_sa    = w_signed & a[WIDTH-1];
  assign w_sb    = w_signed & b[WIDTH-1];
  assign w_mag_a = w_sa ? -a : a;
  assign w_mag_b = w_sb ? -b : b;
  assign w_dz    = w_is_div && (b == '0);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_fast_prod;
  assign w_skip_calc = w_dz || !w_is_div;
  assign w_fast_prod = (2*WIDTH)'(w_mag_a) * (2*WIDTH)'(w_mag_b);
`else
  assign w_skip_calc = w_dz;
`endif

  always_comb begin
    w_acc_init = {{WIDTH{1'b0}}, w_mag_b};
    if (w_dz)          w_acc_init = {a, {WIDTH{1'b1}}};
    else if (w_is_div) w_acc_init = {{WIDTH{1'b0}}, w_mag_a};
`ifdef MULDIV_FAST_MUL_EN
    else               w_acc_init = w_fast_prod;
`endif
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_div  (r_div),
    .i_acc  (r_acc),
    .i_opnd (r_opnd),
    .o_acc  (w_step)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_launch = 1'b0;
    w_last   = (r_cnt == CNT_W'(WIDTH - 1));
    case (r_state)
      ST_IDLE: if (start) begin
        w_launch = 1'b1;
        w_next   = w_skip_calc ? ST_FIX : ST_CALC;
      end
      ST_CALC: if (w_last) w_next = ST_FIX;
      ST_FIX:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    if (flush) begin
      w_next   = ST_IDLE;
      w_launch = 1'b0;
    end
  end

  // Divide-by-zero results are preloaded into the accumulator and bypass the sign fixup.
  always_comb begin
    w_prod = r_neg ? -r_acc : r_acc;
    w_quo  = r_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_rem  = r_rneg ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    if (r_dz) begin
      w_res_hi = r_acc[2*WIDTH-1:WIDTH];
      w_res_lo = r_acc[WIDTH-1:0];
    end else if (r_div) begin
      w_res_hi = w_rem;
      w_res_lo = w_quo;
    end else begin
      w_res_hi = w_prod[2*WIDTH-1:WIDTH];
      w_res_lo = w_prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_acc  <= '0;
      r_opnd <= '0;
      r_div  <= 1'b0;
      r_neg  <= 1'b0;
      r_rneg <= 1'b0;
      r_dz   <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_launch) begin
        r_cnt  <= '0;
        r_acc  <= w_acc_init;
        r_opnd <= w_is_div ? w_mag_b : w_mag_a;
        r_div  <= w_is_div;
        r_neg  <= w_sa ^ w_sb;
        r_rneg <= w_sa;
        r_dz   <= w_dz;
      end else if (r_state == ST_CALC) begin
        r_acc <= w_step;
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (r_state == ST_IDLE) begin
        if (mthi) r_hi <= wdata;
        if (mtlo) r_lo <= wdata;
      end else if (r_state == ST_FIX && !flush) begin
        r_hi   <= w_res_hi;
        r_lo   <= w_res_lo;
        r_done <= 1'b1;
      end
    end
  end

  assign busy = (r_state != ST_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
